aes_inv_state_regs2: RTL and testbench



---
 rtl/aes_inv_state_regs2.sv | 122 ++++++++++++
 tb/tb_aes_inv_state_regs2.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_state_regs2.sv
// Byte-serial 128-bit state register for one share of the threshold AES decryption datapath.
// Handles serial load/unload, InvShiftRows on the final load byte and a 4-step in-place InvMixColumns.

module aes_inv_mixcol (
    input  logic [3:0][7:0] ColxDI,
    output logic [3:0][7:0] ColxDO
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // b_r = 14*a_r ^ 11*a_(r+1) ^ 13*a_(r+2) ^ 9*a_(r+3), built from the x2/x4/x8 multiples
    function automatic logic [7:0] invMcByte(input logic [7:0] a0, input logic [7:0] a1,
                                             input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] m14, m11, m13, m9;
        m14 = xtime(xtime(xtime(a0))) ^ xtime(xtime(a0)) ^ xtime(a0);
        m11 = xtime(xtime(xtime(a1))) ^ xtime(a1) ^ a1;
        m13 = xtime(xtime(xtime(a2))) ^ xtime(xtime(a2)) ^ a2;
        m9  = xtime(xtime(xtime(a3))) ^ a3;
        return m14 ^ m11 ^ m13 ^ m9;
    endfunction

    assign ColxDO[0] = invMcByte(ColxDI[0], ColxDI[1], ColxDI[2], ColxDI[3]);
    assign ColxDO[1] = invMcByte(ColxDI[1], ColxDI[2], ColxDI[3], ColxDI[0]);
    assign ColxDO[2] = invMcByte(ColxDI[2], ColxDI[3], ColxDI[0], ColxDI[1]);
    assign ColxDO[3] = invMcByte(ColxDI[3], ColxDI[0], ColxDI[1], ColxDI[2]);

endmodule

module aes_inv_state_regs2 (
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic [7:0] StateInxDI,
    input  logic       InvShiftRowsxSI,
    input  logic       InvMixColumnsxSI,
    input  logic       FirstRoundxSI,
    output logic [7:0] StateOutxDO,
    output logic [7:0] S21xDO,
    output logic       BusyxSO
);

    // StatexDP[r][c] holds byte S_rc
    logic [3:0][3:0][7:0] StatexDP, StatexDN;
    logic [1:0]           McCntxDP, McCntxDN;
    logic                 McActivexSP, McActivexSN;
    logic [3:0][7:0]      McColxD;

    aes_inv_mixcol uMixCol (
        .ColxDI ({StatexDP[3][0], StatexDP[2][0], StatexDP[1][0], StatexDP[0][0]}),
        .ColxDO (McColxD)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        StatexDN    = StatexDP;
        McCntxDN    = McCntxDP;
        McActivexSN = McActivexSP;

        if (McActivexSP || (InvMixColumnsxSI && !FirstRoundxSI && !InvShiftRowsxSI)) begin
            // One InvMixColumns step: columns move left, mixed column 0 re-enters as column 3
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 4; r++) begin
                    StatexDN[r][c] = StatexDP[r][c+1];
                end
            end
            for (int r = 0; r < 4; r++) begin
                StatexDN[r][3] = McColxD[r];
            end
            if (McActivexSP) begin
                McCntxDN = McCntxDP + 2'd1;
                if (McCntxDP == 2'd3) McActivexSN = 1'b0;
            end else begin
                McCntxDN    = 2'd1;
                McActivexSN = 1'b1;
            end
        end else if (InvShiftRowsxSI) begin
            for (int c = 0; c < 4; c++) begin
                StatexDN[0][c] = StatexDP[1][c];
            end
            StatexDN[1] = {StatexDP[2][2], StatexDP[2][1], StatexDP[2][0], StatexDP[2][3]};
            StatexDN[2] = {StatexDP[3][1], StatexDP[3][0], StatexDP[3][3], StatexDP[3][2]};
            StatexDN[3] = {StatexDP[0][1], StatexDI_sel(StateInxDI), StatexDP[0][3], StatexDP[0][2]};
        end else if (InvMixColumnsxSI && FirstRoundxSI) begin
            StatexDN = StatexDP;
        end else begin
            for (int c = 0; c < 3; c++) begin
                StatexDN[0][c] = StatexDP[1][c];
                StatexDN[1][c] = StatexDP[2][c];
                StatexDN[2][c] = StatexDP[3][c];
                StatexDN[3][c] = StatexDP[0][c+1];
            end
            StatexDN[0][3] = StatexDP[1][3];
            StatexDN[1][3] = StatexDP[2][3];
            StatexDN[2][3] = StatexDP[3][3];
            StatexDN[3][3] = StateInxDI;
        end
    end

    function automatic logic [7:0] StatexDI_sel(input logic [7:0] d);
        return d;
    endfunction

    // The state bytes are architectural and must read 0x00 after reset, so all are reset.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            StatexDP    <= '0;
            McCntxDP    <= 2'd0;
            McActivexSP <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            StatexDP    <= StatexDN;
            McCntxDP    <= McCntxDN;
            McActivexSP <= McActivexSN;
        end
    end

    assign StateOutxDO = StatexDP[0][0];
    assign S21xDO      = StatexDP[2][1];
    assign BusyxSO     = McActivexSP;

endmodule

// File: tb/tb_aes_inv_state_regs2.sv
// Scoreboard bench for aes_inv_state_regs2: expected serial output bytes are queued as stimulus is driven.
`timescale 1ns/1ps

module tb_aes_inv_state_regs2;

    logic       ClkxCI = 1'b0;
    logic       RstxBI;
    logic [7:0] StateInxDI;
    logic       InvShiftRowsxSI;
    logic       InvMixColumnsxSI;
    logic       FirstRoundxSI;
    logic [7:0] StateOutxDO;
    logic [7:0] S21xDO;
    logic       BusyxSO;

    int errors = 0;
    int checks = 0;
    logic [7:0] expQ[$];
    logic [7:0] exp;

    aes_inv_state_regs2 dut (
        .ClkxCI           (ClkxCI),
        .RstxBI           (RstxBI),
        .StateInxDI       (StateInxDI),
        .InvShiftRowsxSI  (InvShiftRowsxSI),
        .InvMixColumnsxSI (InvMixColumnsxSI),
        .FirstRoundxSI    (FirstRoundxSI),
        .StateOutxDO      (StateOutxDO),
        .S21xDO           (S21xDO),
        .BusyxSO          (BusyxSO)
    );

    always #5 ClkxCI = ~ClkxCI;

    // Drive one cycle's inputs just after a falling edge, then advance to the next falling edge.
    task automatic cycle(input logic [7:0] din, input logic isr, input logic imc, input logic fr);
        StateInxDI       = din;
        InvShiftRowsxSI  = isr;
        InvMixColumnsxSI = imc;
        FirstRoundxSI    = fr;
        @(negedge ClkxCI);
    endtask

    task automatic loadColumns(input logic [31:0] col, input logic isrLast);
        logic [7:0] b [4];
        b[0] = col[31:24]; b[1] = col[23:16]; b[2] = col[15:8]; b[3] = col[7:0];
        for (int k = 0; k < 16; k++) cycle(b[k % 4], isrLast && (k == 15), 1'b0, 1'b0);
    endtask

    // Unload whatever the scoreboard holds, comparing the serial output before each shift.
    task automatic drainQueue(input string name);
        int n;
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            exp = expQ.pop_front();
            checks++;
            if (StateOutxDO !== exp) begin
                errors++;
                $display("FAIL %s byte %0d: got %02h expected %02h", name, i, StateOutxDO, exp);
            end
            cycle(8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        RstxBI = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (StateOutxDO !== 8'h00 || S21xDO !== 8'h00 || BusyxSO !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got out=%02h s21=%02h busy=%b expected 00 00 0",
                         StateOutxDO, S21xDO, BusyxSO);
            end
        end
        RstxBI = 1'b1;
        for (int i = 0; i < 16; i++) expQ.push_back(8'h00);
        drainQueue("reset_shift");
    endtask

    task automatic test_inv_shift_rows();
        logic [7:0] order [16];
        order = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                  8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
        for (int k = 0; k < 16; k++) begin
            cycle(8'(k), k == 15, 1'b0, 1'b0);
            expQ.push_back(order[k]);
        end
        checks++;
        if (S21xDO !== 8'h0E) begin
            errors++;
            $display("FAIL isr_s21_tap: got %02h expected 0e", S21xDO);
        end
        drainQueue("inv_shift_rows");
    endtask

    task automatic test_inv_mix_columns(input logic junkDuringBusy);
        loadColumns(32'h8E4DA1BC, 1'b0);
        checks++;
        if (BusyxSO !== 1'b0) begin
            errors++;
            $display("FAIL imc_busy_pre: got %b expected 0", BusyxSO);
        end
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (BusyxSO !== 1'b1) begin
                errors++;
                $display("FAIL imc_busy_step%0d: got %b expected 1", i + 1, BusyxSO);
            end
            if (junkDuringBusy) cycle(8'($urandom), 1'b1, 1'b1, 1'b0);
            else                cycle(8'h00, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (BusyxSO !== 1'b0) begin
            errors++;
            $display("FAIL imc_busy_end: got %b expected 0", BusyxSO);
        end
        for (int c = 0; c < 4; c++) begin
            expQ.push_back(8'hDB); expQ.push_back(8'h13);
            expQ.push_back(8'h53); expQ.push_back(8'h45);
        end
        drainQueue(junkDuringBusy ? "imc_ignore_busy" : "inv_mix_columns");
    endtask

    task automatic test_first_round();
        loadColumns(32'h8E4DA1BC, 1'b0);
        cycle(8'h77, 1'b0, 1'b1, 1'b1);
        checks++;
        if (BusyxSO !== 1'b0 || StateOutxDO !== 8'h8E || S21xDO !== 8'hA1) begin
            errors++;
            $display("FAIL first_round_hold: got busy=%b out=%02h s21=%02h expected 0 8e a1",
                     BusyxSO, StateOutxDO, S21xDO);
        end
        for (int c = 0; c < 4; c++) begin
            expQ.push_back(8'h8E); expQ.push_back(8'h4D);
            expQ.push_back(8'hA1); expQ.push_back(8'hBC);
        end
        drainQueue("first_round");
    endtask

    task automatic test_reset_mid_imc();
        loadColumns(32'h8E4DA1BC, 1'b0);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        #2 RstxBI = 1'b0;
        #1;
        checks++;
        if (StateOutxDO !== 8'h00 || S21xDO !== 8'h00 || BusyxSO !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_imc: got out=%02h s21=%02h busy=%b expected 00 00 0",
                     StateOutxDO, S21xDO, BusyxSO);
        end
        @(negedge ClkxCI);
        RstxBI = 1'b1;
        for (int i = 0; i < 16; i++) expQ.push_back(8'h00);
        for (int i = 0; i < 16; i++) begin
            exp = expQ.pop_front();
            checks++;
            if (StateOutxDO !== exp) begin
                errors++;
                $display("FAIL post_reset_shift %0d: got %02h expected %02h", i, StateOutxDO, exp);
            end
            cycle(8'h5A, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (StateOutxDO !== 8'h5A) begin
            errors++;
            $display("FAIL post_reset_latency: got %02h expected 5a", StateOutxDO);
        end
    endtask

    initial begin
        RstxBI = 1'b0;
        StateInxDI = 8'h00; InvShiftRowsxSI = 1'b0; InvMixColumnsxSI = 1'b0; FirstRoundxSI = 1'b0;
        @(negedge ClkxCI);
        test_reset();
        test_inv_shift_rows();
        test_inv_mix_columns(1'b0);
        test_first_round();
        test_inv_mix_columns(1'b1);
        test_reset_mid_imc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
